la_wb_res_arbiter: RTL

- Arbitrates a single shared user-project resource port (register file / node datapath) between two requesters: the Wishbone slave path from the management core and the logic-analyzer (LA) probe path driven by firmware.
- Round-robin grant, one transaction in flight, optional ack watchdog.
- Exports a 6-bit status code that the top level routes to mprj_io[25:20] for firmware/testbench progress monitoring.

---
 rtl/la_wb_res_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/la_wb_res_arbiter.sv
// la_wb_res_arbiter: round-robin WB / LA arbiter for a single shared resource port.
// Define ARB_TIMEOUT_EN to enable the res_ack_i watchdog (TIMEOUT cycles).
module la_wb_res_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [AW-1:0] wbs_adr_i,
  input  logic [DW-1:0] wbs_dat_i,
  output logic [DW-1:0] wbs_dat_o,
  output logic          wbs_ack_o,
  input  logic          la_req_i,
  input  logic          la_we_i,
  input  logic [AW-1:0] la_adr_i,
  input  logic [DW-1:0] la_dat_i,
  output logic [DW-1:0] la_dat_o,
  output logic          la_done_o,
  output logic          res_req_o,
  output logic          res_we_o,
  output logic [AW-1:0] res_adr_o,
  output logic [DW-1:0] res_wdat_o,
  input  logic [DW-1:0] res_rdat_i,
  input  logic          res_ack_i,
  output logic [5:0]    status_o,
  output logic          busy_o,
  output logic          err_o
);

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("la_wb_res_arbiter: TIMEOUT must be 1..65535");
  end

  localparam logic [5:0] ST_OK    = 6'd1;
  localparam logic [5:0] ST_BUSY  = 6'd2;
  localparam logic [5:0] ST_ABORT = 6'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_ACK,
    S_RESP,
    S_LA_HOLD
  } state_t;

  state_t        r_state;
  logic          r_gnt_la;
  logic          r_last_la;
  logic [DW-1:0] r_wbs_dat;
  logic          r_wbs_ack;
  logic [DW-1:0] r_la_dat;
  logic          r_la_done;
  logic          r_res_req;
  logic          r_res_we;
  logic [AW-1:0] r_res_adr;
  logic [DW-1:0] r_res_wdat;
  logic [5:0]    r_status;
  logic          r_busy;

  logic          w_wb_pend;
  logic          w_la_pend;
  logic          w_gnt_la;
  logic          w_to;
  logic          w_done;
  logic [DW-1:0] w_rdat;

  assign w_wb_pend = wbs_cyc_i & wbs_stb_i;
  assign w_la_pend = la_req_i & ~r_la_done;
  // On a tie the requester that did not win last time gets the grant.
  assign w_gnt_la  = w_la_pend & (~w_wb_pend | ~r_last_la);

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] LP_TO_LAST = 16'(TIMEOUT - 1);

  logic [15:0] r_cnt;
  logic        r_err;

  // A res_ack_i arriving in the timeout cycle wins over the abort.
  assign w_to  = (r_state == S_WAIT_ACK) & (r_cnt == LP_TO_LAST) & ~res_ack_i;
  assign err_o = r_err;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT_ACK) begin
        r_cnt <= r_cnt + 16'd1;
        if (w_done) begin
          r_err <= w_to;
        end
      end
    end
  end
`else
  assign w_to  = 1'b0;
  assign err_o = 1'b0;
`endif

  assign w_done = res_ack_i | w_to;
  assign w_rdat = w_to ? {DW{1'b1}} : res_rdat_i;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      r_state    <= S_IDLE;
      r_gnt_la   <= 1'b0;
      r_last_la  <= 1'b1;
      r_wbs_dat  <= '0;
      r_wbs_ack  <= 1'b0;
      r_la_dat   <= '0;
      r_la_done  <= 1'b0;
      r_res_req  <= 1'b0;
      r_res_we   <= 1'b0;
      r_res_adr  <= '0;
      r_res_wdat <= '0;
      r_status   <= '0;
      r_busy     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_wb_pend | w_la_pend) begin
            r_gnt_la   <= w_gnt_la;
            r_last_la  <= w_gnt_la;
            r_res_we   <= w_gnt_la ? la_we_i  : wbs_we_i;
            r_res_adr  <= w_gnt_la ? la_adr_i : wbs_adr_i;
            r_res_wdat <= w_gnt_la ? la_dat_i : wbs_dat_i;
            r_res_req  <= 1'b1;
            r_busy     <= 1'b1;
            r_status   <= ST_BUSY;
            r_state    <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (w_done) begin
            r_res_req <= 1'b0;
            r_busy    <= 1'b0;
            r_status  <= w_to ? ST_ABORT : ST_OK;
            if (r_gnt_la) begin
              r_la_dat  <= w_rdat;
              r_la_done <= 1'b1;
            end else begin
              r_wbs_dat <= w_rdat;
              r_wbs_ack <= 1'b1;
            end
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_wbs_ack <= 1'b0;
          r_state   <= r_gnt_la ? S_LA_HOLD : S_IDLE;
        end
        S_LA_HOLD: begin
          if (!la_req_i) begin
            r_la_done <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wbs_dat_o  = r_wbs_dat;
  assign wbs_ack_o  = r_wbs_ack;
  assign la_dat_o   = r_la_dat;
  assign la_done_o  = r_la_done;
  assign res_req_o  = r_res_req;
  assign res_we_o   = r_res_we;
  assign res_adr_o  = r_res_adr;
  assign res_wdat_o = r_res_wdat;
  assign status_o   = r_status;
  assign busy_o     = r_busy;

endmodule
